// File: rtl/afio_nch_pkg.sv
// Shared constants and helpers for the alternate-function I/O block.
package afio_nch_pkg;

    // Function-select code that hands a pin to the GPIO controller.
    localparam int unsigned FSEL_GPIO = 0;

    // Width of the filter length field and of each per-pin filter counter.
    localparam int unsigned FLT_LEN_W = 4;

    // Smallest select width able to encode GPIO plus naf alternate functions.
    function automatic int unsigned fsel_width(input int unsigned naf);
        return $clog2(naf + 1);
    endfunction

    // Bit position of AF k (1-based), pin i inside the packed af_di/af_dir vectors.
    function automatic int unsigned af_bit(input int unsigned k, input int unsigned i,
                                           input int unsigned n);
        return (k - 1) * n + i;
    endfunction

endpackage

// File: rtl/afio_nch_if.sv
// Controller-side bundle: GPIO/AF output data and directions, pin selects, filtered inputs.
interface afio_nch_if #(
    parameter int unsigned N   = 32,
    parameter int unsigned NAF = 3,
    parameter int unsigned FW  = 3
);
    logic [N-1:0]     gpio_di;
    logic [N-1:0]     gpio_dir;
    logic [N-1:0]     gpio_do;
    logic [N*FW-1:0]  fsel;
    logic [NAF*N-1:0] af_di;
    logic [NAF*N-1:0] af_dir;
    logic [N-1:0]     af_do;

    modport master (
        output gpio_di, gpio_dir, fsel, af_di, af_dir,
        input  gpio_do, af_do
    );

    modport slave (
        input  gpio_di, gpio_dir, fsel, af_di, af_dir,
        output gpio_do, af_do
    );
endinterface

// File: rtl/afio_nch_pin_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, tick-qualified glitch filter, edge detect.
module afio_nch_pin_filter
    import afio_nch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pad_i,
    input  logic                 tick_i,
    input  logic                 flt_en_i,
    input  logic [FLT_LEN_W-1:0] flt_len_i,
    output logic                 filt_o,
    output logic                 rise_o,
    output logic                 fall_o
);
    logic [1:0]           sync_q;
    logic                 filt_q, filt_d;
    logic [FLT_LEN_W-1:0] cnt_q, cnt_d;

    // Synchroniser chain plus filter state; sync_q[1] is the metastability-safe sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pad_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    // Filter: accept a new level only after flt_len+1 consecutive differing ticks.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (!flt_en_i) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
        end else if (tick_i) begin
            if (sync_q[1] == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == flt_len_i) begin
                filt_d = sync_q[1];
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + FLT_LEN_W'(1);
            end
        end
    end

    // Edges are flagged in the cycle the filtered level is about to change.
    always_comb begin
        filt_o = filt_q;
        rise_o = filt_d & ~filt_q;
        fall_o = ~filt_d & filt_q;
    end

endmodule

// File: rtl/afio_nch.sv
// Alternate-function I/O: per-pin output mux, shared filter prescaler, per-pin edge interrupts.
module afio_nch
    import afio_nch_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned NAF = 3,
    parameter int unsigned FW  = 3,
    parameter int unsigned PW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inout  wire  [N-1:0]         pad_io,
    afio_nch_if.slave            bus,
    input  logic [N-1:0]         flt_en_i,
    input  logic [PW-1:0]        flt_div_i,
    input  logic [FLT_LEN_W-1:0] flt_len_i,
    input  logic [N-1:0]         irq_rise_en_i,
    input  logic [N-1:0]         irq_fall_en_i,
    input  logic [N-1:0]         irq_clr_i,
    output logic [N-1:0]         irq_pend_o,
    output logic                 irq_o
);
    logic [N-1:0]  sel_any, sel_af, pad_oe, pad_do;
    logic [N-1:0]  filt, rise, fall;
    logic [N-1:0]  pend_q, pend_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          tick;

    // Output mux: a valid AF select overrides GPIO; an out-of-range select leaves the pin input-only.
    always_comb begin
        sel_any = '0;
        sel_af  = '0;
        pad_oe  = '0;
        pad_do  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_any[i] = bus.fsel[i*FW +: FW] != FW'(FSEL_GPIO);
            sel_af[i]  = sel_any[i] && (bus.fsel[i*FW +: FW] <= FW'(NAF));
            if (!sel_any[i]) begin
                pad_oe[i] = bus.gpio_dir[i];
                pad_do[i] = bus.gpio_di[i];
            end
            for (int unsigned k = 1; k <= NAF; k++) begin
                if (bus.fsel[i*FW +: FW] == FW'(k)) begin
                    pad_oe[i] = bus.af_dir[af_bit(k, i, N)];
                    pad_do[i] = bus.af_di[af_bit(k, i, N)];
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pin
        assign pad_io[g] = pad_oe[g] ? pad_do[g] : 1'bz;

        afio_nch_pin_filter u_flt (
            .clk       (clk),
            .rst_n     (rst_n),
            .pad_i     (pad_io[g]),
            .tick_i    (tick),
            .flt_en_i  (flt_en_i[g]),
            .flt_len_i (flt_len_i),
            .filt_o    (filt[g]),
            .rise_o    (rise[g]),
            .fall_o    (fall[g])
        );
    end

    // Prescaler: >= compare so shrinking flt_div mid-count cannot strand the counter.
    always_comb begin
        tick = pc_q >= flt_div_i;
        pc_d = tick ? '0 : pc_q + PW'(1);
    end

    // Pending bits: a new enabled edge wins over a simultaneous clear.
    always_comb begin
        pend_d = (pend_q & ~irq_clr_i) | (rise & irq_rise_en_i) | (fall & irq_fall_en_i);
    end

    // Shared prescaler and interrupt state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            pend_q <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
        end
    end

    assign bus.gpio_do = filt & ~sel_any;
    assign bus.af_do   = filt & sel_af;
    assign irq_pend_o  = pend_q;
    assign irq_o       = |pend_q;

endmodule

// File: tb/tb_afio_nch.sv
// Bench for afio_nch: directed scenarios plus randomized traffic against a behavioural model.
module tb_afio_nch;
    localparam int N   = 32;
    localparam int NAF = 3;
    localparam int FW  = 3;
    localparam int PW  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wire  [N-1:0]  pad;
    logic [N-1:0]  pad_want, pad_val, exp_oe, exp_dout;
    logic [N-1:0]  flt_en, irq_rise_en, irq_fall_en, irq_clr, irq_pend;
    logic [PW-1:0] flt_div;
    logic [3:0]    flt_len;
    logic          irq;

    afio_nch_if #(.N(N), .NAF(NAF), .FW(FW)) bus ();

    // Bench drives a pad only where the DUT is expected to be high-impedance; pull-ups elsewhere.
    for (genvar g = 0; g < N; g++) begin : g_pad
        assign pad[g] = (pad_want[g] && !exp_oe[g]) ? pad_val[g] : 1'bz;
        pullup (pad[g]);
    end

    afio_nch #(.N(N), .NAF(NAF), .FW(FW), .PW(PW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pad_io        (pad),
        .bus           (bus),
        .flt_en_i      (flt_en),
        .flt_div_i     (flt_div),
        .flt_len_i     (flt_len),
        .irq_rise_en_i (irq_rise_en),
        .irq_fall_en_i (irq_fall_en),
        .irq_clr_i     (irq_clr),
        .irq_pend_o    (irq_pend),
        .irq_o         (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: sampled pad history, tick-run length per pin, filtered level, pending.
    logic [N-1:0] m_s0, m_s1, m_filt, m_pend;
    int           m_run[N];
    int           m_pc;

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_filt = '0; m_pend = '0; m_pc = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic [N-1:0] pad_now);
        bit   tick;
        logic old;
        tick = (m_pc >= int'(flt_div));
        m_pc = tick ? 0 : m_pc + 1;
        for (int i = 0; i < N; i++) begin
            old = m_filt[i];
            if (!flt_en[i]) begin
                m_filt[i] = m_s1[i];
                m_run[i]  = 0;
            end else if (tick) begin
                if (m_s1[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] > int'(flt_len)) begin
                        m_filt[i] = m_s1[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pend[i] = (m_pend[i] && !irq_clr[i]) || (!old && m_filt[i] && irq_rise_en[i])
                        || (old && !m_filt[i] && irq_fall_en[i]);
            m_s1[i] = m_s0[i];
            m_s0[i] = pad_now[i];
        end
    endtask

    task automatic compute_exp();
        int f;
        for (int i = 0; i < N; i++) begin
            f = int'(bus.fsel[i*FW +: FW]);
            if (f == 0) begin
                exp_oe[i] = bus.gpio_dir[i]; exp_dout[i] = bus.gpio_di[i];
            end else if (f <= NAF) begin
                exp_oe[i] = bus.af_dir[(f-1)*N+i]; exp_dout[i] = bus.af_di[(f-1)*N+i];
            end else begin
                exp_oe[i] = 1'b0; exp_dout[i] = 1'b0;
            end
        end
    endtask

    // One clock: check pads from current inputs, advance the model, check registered outputs.
    task automatic cycle();
        logic [N-1:0] exp_pad, exp_g, exp_a;
        int f;
        compute_exp();
        #1;
        for (int i = 0; i < N; i++)
            exp_pad[i] = exp_oe[i] ? exp_dout[i] : (pad_want[i] ? pad_val[i] : 1'b1);
        check_eq("pad", 64'(pad), 64'(exp_pad));
        if (!rst_n) model_reset();
        else        model_step(exp_pad);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            f = int'(bus.fsel[i*FW +: FW]);
            exp_g[i] = m_filt[i] && (f == 0);
            exp_a[i] = m_filt[i] && (f >= 1) && (f <= NAF);
        end
        check_eq("gpio_do", 64'(bus.gpio_do), 64'(exp_g));
        check_eq("af_do", 64'(bus.af_do), 64'(exp_a));
        check_eq("irq_pend", 64'(irq_pend), 64'(m_pend));
        check_eq("irq", 64'(irq), 64'(|m_pend));
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clear_all();
        irq_clr = '1;
        cycle();
        irq_clr = '0;
    endtask

    int lat;
    logic seen;

    initial begin
        rst_n = 1'b0;
        bus.gpio_di = '0; bus.gpio_dir = '0; bus.fsel = '0; bus.af_di = '0; bus.af_dir = '0;
        flt_en = '0; flt_div = '0; flt_len = '0;
        irq_rise_en = '0; irq_fall_en = '0; irq_clr = '0;
        pad_want = 32'h0000_ffff; pad_val = '1; exp_oe = '0; exp_dout = '0;
        model_reset();
        @(negedge clk);

        // Reset with pads high: nothing propagates, undriven pads are released.
        cycles(3);
        check_eq("rst_gpio_do", 64'(bus.gpio_do), 64'd0);
        check_eq("rst_af_do", 64'(bus.af_do), 64'd0);
        check_eq("rst_irq", 64'(irq), 64'd0);
        check_eq("rst_pad31_z", 64'(pad[31]), 64'd1);
        rst_n = 1'b1;
        pad_want = '0;
        cycles(4);

        // AF routing on pin 3, then an invalid select.
        bus.fsel[3*FW +: FW] = 3'd2;
        bus.af_dir[N+3] = 1'b1; bus.af_di[N+3] = 1'b1; bus.gpio_di[3] = 1'b0;
        cycle();
        check_eq("af_pad_hi", 64'(pad[3]), 64'd1);
        bus.af_di[N+3] = 1'b0;
        cycle();
        check_eq("af_pad_lo", 64'(pad[3]), 64'd0);
        bus.fsel[3*FW +: FW] = 3'd5;
        bus.gpio_dir[3] = 1'b1;
        cycle();
        check_eq("inv_pad_z", 64'(pad[3]), 64'd1);
        pad_want[3] = 1'b1; pad_val[3] = 1'b1;
        cycles(5);
        check_eq("inv_gpio_do", 64'(bus.gpio_do[3]), 64'd0);
        check_eq("inv_af_do", 64'(bus.af_do[3]), 64'd0);
        bus.fsel = '0; bus.gpio_dir = '0; bus.af_dir = '0; bus.af_di = '0;
        pad_want = '0;
        cycles(4);

        // Filter disabled: 3-cycle latency, rise pending in the same cycle.
        pad_want[0] = 1'b1; pad_val[0] = 1'b0;
        cycles(4);
        clear_all();
        irq_rise_en[0] = 1'b1;
        pad_val[0] = 1'b1;
        cycles(2);
        check_eq("nf_lat2_do", 64'(bus.gpio_do[0]), 64'd0);
        check_eq("nf_lat2_pend", 64'(irq_pend[0]), 64'd0);
        cycle();
        check_eq("nf_lat3_do", 64'(bus.gpio_do[0]), 64'd1);
        check_eq("nf_lat3_pend", 64'(irq_pend[0]), 64'd1);
        check_eq("nf_lat3_irq", 64'(irq), 64'd1);

        // Filter enabled, flt_div=3, flt_len=2: short glitch rejected, long level accepted.
        pad_val[0] = 1'b0;
        cycles(4);
        flt_div = 16'd3; flt_len = 4'd2; flt_en[0] = 1'b1;
        clear_all();
        seen = 1'b0;
        pad_val[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin cycle(); seen |= bus.gpio_do[0] | irq_pend[0]; end
        pad_val[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin cycle(); seen |= bus.gpio_do[0] | irq_pend[0]; end
        check_eq("flt_glitch", 64'(seen), 64'd0);
        pad_val[0] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (lat < 0 && bus.gpio_do[0]) lat = k;
        end
        check_eq("flt_lat_in_range", 64'((lat >= 11) && (lat <= 14)), 64'd1);
        check_eq("flt_pend", 64'(irq_pend[0]), 64'd1);

        // Clear racing a new fall edge on pin 5.
        irq_rise_en = '0; flt_en = '0;
        pad_want[5] = 1'b1; pad_val[5] = 1'b1;
        cycles(4);
        irq_fall_en[5] = 1'b1;
        clear_all();
        pad_val[5] = 1'b0;
        cycles(3);
        check_eq("race_first_fall", 64'(irq_pend[5]), 64'd1);
        pad_val[5] = 1'b1;
        cycles(4);
        pad_val[5] = 1'b0;
        cycles(2);
        irq_clr[5] = 1'b1;
        cycle();
        irq_clr[5] = 1'b0;
        check_eq("race_set_wins", 64'(irq_pend[5]), 64'd1);
        check_eq("race_irq", 64'(irq), 64'd1);
        irq_clr[5] = 1'b1;
        cycle();
        irq_clr[5] = 1'b0;
        check_eq("lone_clr", 64'(irq_pend[5]), 64'd0);
        check_eq("lone_clr_irq", 64'(irq), 64'd0);
        irq_fall_en = '0;

        // Reset in the middle of a filter count.
        pad_val[0] = 1'b0;
        cycles(4);
        flt_en[0] = 1'b1; flt_div = 16'd3; flt_len = 4'd2; irq_rise_en[0] = 1'b1;
        clear_all();
        pad_val[0] = 1'b1;
        cycles(6);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_gpio_do", 64'(bus.gpio_do), 64'd0);
        check_eq("mid_rst_pend", 64'(irq_pend), 64'd0);
        cycle();
        rst_n = 1'b1;
        cycles(11);
        check_eq("post_rst_11", 64'(irq_pend[0]), 64'd0);
        cycle();
        check_eq("post_rst_12", 64'(irq_pend[0]), 64'd1);
        irq_clr[0] = 1'b1;
        cycle();
        irq_clr[0] = 1'b0;
        cycles(20);
        check_eq("post_rst_once", 64'(irq_pend[0]), 64'd0);

        // Randomized traffic in segments, each starting from reset with a fixed flt_len.
        for (int seg = 0; seg < 4; seg++) begin
            rst_n = 1'b0;
            cycle();
            rst_n = 1'b1;
            flt_len = 4'($urandom_range(0, 3));
            for (int c = 0; c < 160; c++) begin
                if (c % 32 == 0) begin
                    for (int i = 0; i < N; i++)
                        bus.fsel[i*FW +: FW] = ($urandom_range(0, 1) == 0) ? 3'd0
                                                : 3'($urandom_range(0, 7));
                    bus.gpio_dir = $urandom; bus.gpio_di = $urandom;
                    bus.af_dir = {$urandom, $urandom, $urandom};
                    bus.af_di  = {$urandom, $urandom, $urandom};
                end
                if (c % 64 == 0) pad_want = $urandom | $urandom;
                if (c % 16 == 0) flt_en = $urandom;
                if (c % 20 == 0) begin irq_rise_en = $urandom; irq_fall_en = $urandom; end
                if (c % 50 == 0) flt_div = 16'($urandom_range(0, 3));
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 5) == 0) pad_val[i] = ~pad_val[i];
                irq_clr = $urandom & $urandom & $urandom;
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/afio_nch.md
Name: afio_nch

Overview:
- Parametrised alternate-function I/O block: N pads, each pad owned by GPIO or by one of NAF alternate-function peripherals, selected per pin.
- Adds a registered input path that the combinational pin mux lacks: 2-flop synchroniser, prescaled glitch filter, per-pin edge-detect interrupt with pending bits.
- Sits between the pad ring and the APB GPIO controller plus the AF peripherals (UART, SPI, timers).
- Control inputs come from the GPIO controller's registers.

Parameters:
- N, 32, number of pads.
- NAF, 3, number of alternate functions per pad (1..7).
- FW, 3, function-select width per pin; must satisfy 2^FW > NAF.
- PW, 16, glitch-filter prescaler width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pad_io  inout  N  pads.
- gpio_di  in  N  GPIO output data.
- gpio_dir  in  N  GPIO direction; 1=output.
- gpio_do  out  N  filtered pad input, GPIO-owned pins only.
- fsel  in  N*FW  per-pin function; 0=GPIO, k=AF k (1..NAF). Pin i uses bits [i*FW +: FW].
- af_di  in  NAF*N  AF output data; AF k pin i at bit (k-1)*N+i.
- af_dir  in  NAF*N  AF direction, same packing.
- af_do  out  N  filtered pad input, AF-owned pins only.
- flt_en  in  N  per-pin glitch-filter enable.
- flt_div  in  PW  prescaler terminal count.
- flt_len  in  4  extra consecutive differing samples needed to change state.
- irq_rise_en  in  N  rising-edge interrupt enable.
- irq_fall_en  in  N  falling-edge interrupt enable.
- irq_clr  in  N  one-cycle write-1-to-clear of pending bits.
- irq_pend  out  N  pending bits.
- irq  out  1  OR of irq_pend.

Behaviour:
- Clock and reset: single clock domain; rst_n asynchronous assert, synchronous deassert (external reset synchroniser).
- Reset values: sync flops, filtered state, filter counters, prescaler and irq_pend all 0. gpio_do, af_do, irq_pend and irq read 0. Pads are Z whenever the selected dir is 0, independent of reset.
- Output path (combinational, zero latency):
  - sel_af[i] = (fsel_i != 0) and (fsel_i <= NAF).
  - Effective dir/data = af_dir/af_di of AF fsel_i if sel_af, else gpio_dir/gpio_di.
  - pad driven when effective dir=1, else Z.
  - fsel_i > NAF: pin is input-only (Z); its filtered value appears on neither gpio_do nor af_do.
- Input sync: 2 flops per pin.
- Prescaler: counter pc increments each cycle. When pc >= flt_div, a tick fires and pc <= 0. flt_div=0 gives a tick every cycle. The >= compare makes shrinking flt_div mid-count safe.
- Filter, per pin:
  - flt_en=0: filt <= sync every cycle; counter held at 0. Pad-to-gpio_do latency is 3 cycles.
  - flt_en=1, on a tick: if sync==filt then cnt <= 0; else if cnt==flt_len then filt <= sync and cnt <= 0; else cnt <= cnt+1. Net effect: filt follows after flt_len+1 consecutive differing ticks.
  - No tick: filt and cnt hold.
  - Toggling flt_en mid-count: cnt clears when flt_en=0.
- Outputs: gpio_do = filt & ~sel_any; af_do = filt & sel_af. sel_any is fsel != 0, which also blocks invalid selections.
- Edge detect:
  - rise_i = filt_next & ~filt; fall_i = ~filt_next & filt.
  - pend set when (rise & irq_rise_en) | (fall & irq_fall_en). Edges are detected regardless of pin ownership.
  - irq_clr clears pend; set and clear in the same cycle: set wins.
  - irq registered-free: combinational OR of irq_pend.
  - Enables affect only future edges; clearing an enable does not clear pend.
- Mid-operation reset: everything returns to reset values immediately. The first edge after release is judged against filt=0, so a pad held high yields one rise event if enabled.

Decomposition:
- Shared package afio_pkg:
  - FSEL_GPIO = 0.
  - Function-select width helper.
  - AF index macros for packed af_di/af_dir slicing.
- Sub-module afio_pin_filter (one instance per pin, generate loop): sync flops, filter counter, filt register, rise/fall outputs.
- The top level holds the shared prescaler, the output mux, and the irq_pend register.

Test Plan:
- Reset: assert rst_n=0 with pads driven high → gpio_do, af_do, irq_pend, irq all 0; pads with gpio_dir=0 are Z.
- AF routing: pin 3 fsel=2, af_dir[N+3]=1, af_di[N+3]=1, gpio_di[3]=0 → pad_io[3]=1. Then fsel=5 with NAF=3 → pad_io[3]=Z, gpio_do[3]=af_do[3]=0.
- Filter disabled: pad 0→1 at cycle 0 → gpio_do rises at cycle 3, irq_pend[0] set at cycle 3 with irq_rise_en=1.
- Filter flt_div=3, flt_len=2:
  - 4-cycle high glitch → gpio_do stays 0, no pend.
  - Sustained high → gpio_do rises in cycle 11..14 after the pad edge.
- Interrupt clear race: irq_clr[5] pulsed in the same cycle as a new enabled fall edge on pin 5 → irq_pend[5] stays 1. A later lone irq_clr clears it and drops irq.
- Reset mid-filter: rst_n pulsed while cnt=1 → cnt and filt return to 0. After release, a pad held high produces exactly one rise pend after flt_len+1 ticks.
